// File: rtl/glitch_pkg.sv
// Shared defaults and state encoding for the input glitch filter.
package glitch_pkg;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 8;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/glitch_sync_chain.sv
// N-flop synchroniser for one asynchronous bit; reusable for any async input.
// Latency N edges; no backpressure.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/glitch_filter.sv
// Synchronise and debounce din; dout changes only after STABLE_CYCLES stable cycles.
// Latency SYNC_STAGES+STABLE_CYCLES-1 edges from sampling; no backpressure.
// GLITCH_CNT_EN adds a saturating glitch_cnt of rejected pulses.
module glitch_filter
    import glitch_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic             rise,
    output logic             fall
`ifdef GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || CNT_W < 1) begin : g_bad_param
        $error("glitch_filter: parameter out of legal range");
    end

    logic    s;
    state_t  state;
    logic [CW-1:0] cnt;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    // The counter holds how many consecutive cycles s has differed from dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STABLE;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (s != dout) begin
                        if (STABLE_CYCLES == 1) begin
                            dout <= s;
                            rise <= s;
                            fall <= ~s;
                        end else begin
                            state <= ST_PENDING;
                            cnt   <= CW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (s == dout) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        dout  <= s;
                        rise  <= s;
                        fall  <= ~s;
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef GLITCH_CNT_EN
    logic glitch_evt;

    assign glitch_evt = (state == ST_PENDING) && (s == dout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != {CNT_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench: default, STABLE_CYCLES=1 and CNT_W=2 instances of glitch_filter.
module tb_glitch_filter;

    logic clk;
    logic rst;
    logic din0, din1, din2;
    logic dout0, rise0, fall0;
    logic dout1, rise1, fall1;
    logic dout2, rise2, fall2;
`ifdef GLITCH_CNT_EN
    logic [7:0] gcnt0;
    logic [7:0] gcnt1;
    logic [1:0] gcnt2;
`endif

    int checks   = 0;
    int failures = 0;

    glitch_filter u0 (
        .clk(clk), .rst(rst), .din(din0), .dout(dout0), .rise(rise0), .fall(fall0)
`ifdef GLITCH_CNT_EN
        , .glitch_cnt(gcnt0)
`endif
    );

    glitch_filter #(.STABLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .din(din1), .dout(dout1), .rise(rise1), .fall(fall1)
`ifdef GLITCH_CNT_EN
        , .glitch_cnt(gcnt1)
`endif
    );

    glitch_filter #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .din(din2), .dout(dout2), .rise(rise2), .fall(fall2)
`ifdef GLITCH_CNT_EN
        , .glitch_cnt(gcnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic d, input logic r, input logic f,
                        input logic ed, input logic er, input logic ef);
        chk({tag, "_dout"}, {31'd0, d}, {31'd0, ed});
        chk({tag, "_rise"}, {31'd0, r}, {31'd0, er});
        chk({tag, "_fall"}, {31'd0, f}, {31'd0, ef});
    endtask

    initial begin
        rst  = 1'b1;
        din0 = 1'b0;
        din1 = 1'b0;
        din2 = 1'b0;

        // Reset held while din toggles
        for (int i = 0; i < 6; i++) begin
            tick(1);
            din0 = ~din0;
            din1 = ~din1;
            din2 = ~din2;
            #1;
            chk0("rst_hold", dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
`ifdef GLITCH_CNT_EN
            chk("rst_gcnt", 32'(gcnt0), 32'd0);
`endif
        end
        tick(1);
        rst  = 1'b0;
        din0 = 1'b0;
        din1 = 1'b0;
        din2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk0("idle", dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
        end

        // STABLE_CYCLES=1: one-cycle pulse passes through
        din1 = 1'b1;
        tick(1);
        din1 = 1'b0;
        chk0("sc1_i1", dout1, rise1, fall1, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            tick(1);
            chk0($sformatf("sc1_i%0d", i), dout1, rise1, fall1,
                 i == 3, i == 3, i == 4);
        end
`ifdef GLITCH_CNT_EN
        chk("sc1_gcnt", 32'(gcnt1), 32'd0);
`endif

        // CNT_W=2: five rejected pulses saturate at 3
        for (int p = 1; p <= 5; p++) begin
            din2 = 1'b1;
            tick(1);
            din2 = 1'b0;
            tick(4);
            chk0($sformatf("sat_p%0d", p), dout2, rise2, fall2, 1'b0, 1'b0, 1'b0);
`ifdef GLITCH_CNT_EN
            chk($sformatf("sat_gcnt_p%0d", p), 32'(gcnt2), (p >= 3) ? 32'd3 : 32'(p));
`endif
        end
        tick(10);
`ifdef GLITCH_CNT_EN
        chk("sat_gcnt_hold", 32'(gcnt2), 32'd3);
`endif

        // Clean rising edge: dout at k+5, one-cycle rise
        din0 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            chk0($sformatf("rise_i%0d", i), dout0, rise0, fall0, i >= 6, i == 6, 1'b0);
        end
        // Clean falling edge
        din0 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            chk0($sformatf("fall_i%0d", i), dout0, rise0, fall0, i < 6, 1'b0, i == 6);
        end

        // Single-cycle pulse rejected
        din0 = 1'b1;
        tick(1);
        din0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk0($sformatf("pulse1_i%0d", i), dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
        end
`ifdef GLITCH_CNT_EN
        chk("pulse1_gcnt", 32'(gcnt0), 32'd1);
`endif

        // Alternating 1,0,1,0 after 100 ns of 0
        tick(10);
        din0 = 1'b1; tick(1);
        din0 = 1'b0; tick(1);
        din0 = 1'b1; tick(1);
        din0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk0($sformatf("alt_i%0d", i), dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
        end
`ifdef GLITCH_CNT_EN
        chk("alt_gcnt", 32'(gcnt0), 32'd3);
`endif

        // 3-cycle pulse: one short of threshold
        din0 = 1'b1;
        tick(3);
        din0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk0($sformatf("p3_i%0d", i), dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
        end
`ifdef GLITCH_CNT_EN
        chk("p3_gcnt", 32'(gcnt0), 32'd4);
`endif

        // 4-cycle pulse: passes, dout high exactly 4 cycles
        din0 = 1'b1;
        tick(4);
        din0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk0($sformatf("p4_i%0d", i), dout0, rise0, fall0,
                 (i >= 2) && (i <= 5), i == 2, i == 6);
        end
`ifdef GLITCH_CNT_EN
        chk("p4_gcnt", 32'(gcnt0), 32'd4);
`endif

        // Reset two cycles into a falling PENDING with dout=1
        din0 = 1'b1;
        tick(8);
        chk("pre_rst_dout", {31'd0, dout0}, 32'd1);
        din0 = 1'b0;
        tick(4);
        chk("pend_dout", {31'd0, dout0}, 32'd1);
        rst = 1'b1;
        #1;
        chk0("rst_async", dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk0($sformatf("rst_mid_i%0d", i), dout0, rise0, fall0, 1'b0, 1'b0, 1'b0);
        end
`ifdef GLITCH_CNT_EN
        chk("rst_mid_gcnt", 32'(gcnt0), 32'd0);
`endif

        // din held high across reset release commits like a normal edge
        rst  = 1'b0;
        din0 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            chk0($sformatf("post_rst_i%0d", i), dout0, rise0, fall0, i >= 6, i == 6, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
